// File: rtl/seven_seg_pkg.sv
// Shared glyph codes and segment constants for the multiplexed seven-segment scanner.
package seven_seg_pkg;

    typedef logic [4:0] glyph_t;

    localparam glyph_t CODE_EQ    = 5'd16;
    localparam glyph_t CODE_BLANK = 5'd17;
    localparam glyph_t CODE_DASH  = 5'd18;

    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational glyph decoder: 5-bit code to active-low segments {g,f,e,d,c,b,a}.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  glyph_t     code,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b0111111;
        case (code)
            5'd0:       seg = 7'h40;
            5'd1:       seg = 7'h79;
            5'd2:       seg = 7'h24;
            5'd3:       seg = 7'h30;
            5'd4:       seg = 7'h19;
            5'd5:       seg = 7'h12;
            5'd6:       seg = 7'h02;
            5'd7:       seg = 7'h78;
            5'd8:       seg = 7'h00;
            5'd9:       seg = 7'h10;
            5'd10:      seg = 7'h08;
            5'd11:      seg = 7'h03;
            5'd12:      seg = 7'h46;
            5'd13:      seg = 7'h21;
            5'd14:      seg = 7'h06;
            5'd15:      seg = 7'h0E;
            CODE_EQ:    seg = 7'b0110111;
            CODE_BLANK: seg = SEG_OFF;
            // CODE_DASH and every higher code fall through to the dash glyph
            default:    seg = 7'b0111111;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// N-digit common-anode scanner with PWM brightness and frame-synchronous double buffering.
// Optional SEVEN_SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_BITS  = 18,
    parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic [3:0]              brightness,
    output logic                    pending,
    output logic                    frame_done,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    logic [SLOT_BITS-1:0]          slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    glyph_t [NUM_DIGITS-1:0]       pend_code_q, pend_code_d, disp_code_q, disp_code_d;
    logic [NUM_DIGITS-1:0]         pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]         pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
    logic                          pending_q, pending_d;
    logic                          frame_done_q, frame_done_d;
    logic [6:0]                    seg_q, seg_d;
    logic                          dp_q, dp_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d;

    logic   slot_end, frame_wrap, apply, lit;
    glyph_t cur_code;
    logic [6:0] cur_seg;

    assign slot_end   = &slot_cnt_q;
    assign frame_wrap = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign apply      = frame_wrap && pending_q;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] supp_q, supp_d, supp_next;
    logic                  run;

    // Zero run from the most significant digit; a lit dp ends it, digit 0 always shows.
    always_comb begin
        run       = 1'b1;
        supp_next = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run          = run && (pend_code_q[k] == 5'd0) && !pend_dp_q[k];
            supp_next[k] = run;
        end
    end

    assign supp_d = apply ? supp_next : supp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) supp_q <= '0;
        else       supp_q <= supp_d;
    end
`endif

    always_comb begin
        slot_cnt_d   = slot_cnt_q + SLOT_BITS'(1);
        idx_d        = idx_q;
        if (slot_end) idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);

        pend_code_d  = load ? digits_in : pend_code_q;
        pend_dp_d    = load ? dp_in     : pend_dp_q;
        pend_blank_d = load ? blank_in  : pend_blank_q;
        // A load coinciding with the wrap stays pending for the following frame.
        pending_d    = load || (pending_q && !frame_wrap);

        disp_code_d  = apply ? pend_code_q  : disp_code_q;
        disp_dp_d    = apply ? pend_dp_q    : disp_dp_q;
        disp_blank_d = apply ? pend_blank_q : disp_blank_q;

        frame_done_d = frame_wrap;
    end

    seven_seg_decoder u_dec (
        .code (cur_code),
        .seg  (cur_seg)
    );

    always_comb begin
        cur_code = disp_code_q[idx_q];
        lit      = !disp_blank_q[idx_q] && (slot_cnt_q[SLOT_BITS-1 -: 4] <= brightness);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        lit      = lit && !supp_q[idx_q];
`endif
        an_d     = '1;
        if (lit) an_d[idx_q] = 1'b0;
        seg_d    = lit ? cur_seg : SEG_OFF;
        dp_d     = lit ? ~disp_dp_q[idx_q] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q   <= '0;
            idx_q        <= '0;
            pend_code_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            disp_code_q  <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '1;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            an_q         <= '1;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            pend_code_q  <= pend_code_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            disp_code_q  <= disp_code_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign pending    = pending_q;
    assign frame_done = frame_done_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (NUM_DIGITS=4, SLOT_BITS=4): stimulus queues expected
// {frame_done, pending, an, seg, dp} per clock edge; a monitor compares at the falling edge.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] digits_in;
    logic [3:0]  dp_in, blank_in, brightness;
    logic        load;
    logic        pending, frame_done, dp;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [13:0] obs;

    typedef struct {
        int          cyc;
        logic [13:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    int    edge_cnt = 0;
    int    checks   = 0;
    int    errors   = 0;

    seven_seg_scanner #(.NUM_DIGITS(4), .SLOT_BITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .brightness (brightness),
        .pending    (pending),
        .frame_done (frame_done),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    assign obs = {frame_done, pending, an, seg, dp};

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
                it = q.pop_front();
                checks++;
                if (it.cyc != edge_cnt) begin
                    errors++;
                    $display("FAIL %s: item for edge %0d not sampled (now %0d)", it.name, it.cyc, edge_cnt);
                end else if (obs !== it.exp) begin
                    errors++;
                    $display("FAIL %s edge %0d: got fd=%b pend=%b an=%b seg=%h dp=%b, need fd=%b pend=%b an=%b seg=%h dp=%b",
                             it.name, edge_cnt, obs[13], obs[12], obs[11:8], obs[7:1], obs[0],
                             it.exp[13], it.exp[12], it.exp[11:8], it.exp[7:1], it.exp[0]);
                end
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'd0:  return 7'h40;
            5'd1:  return 7'h79;
            5'd2:  return 7'h24;
            5'd3:  return 7'h30;
            5'd10: return 7'h08;
            5'd11: return 7'h03;
            5'd12: return 7'h46;
            5'd13: return 7'h21;
            5'd16: return 7'b0110111;
            5'd17: return 7'h7F;
            5'd25: return 7'b0111111;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    task automatic push(input int cyc, input logic [13:0] e, input string n);
        item_t it;
        it.cyc  = cyc;
        it.exp  = e;
        it.name = n;
        q.push_back(it);
    endtask

    // Called on the falling edge right after a frame wrap; covers the next 64 edges.
    task automatic run_frame(input logic [19:0] codes, input logic [3:0] dpv, input logic [3:0] blk,
                             input logic [3:0] br, input bit ps, input int ld_j, input bit pe,
                             input logic [19:0] ld_codes, input logic [3:0] ld_dp,
                             input logic [3:0] ld_blank, input string nm);
        int          e0, k, sl;
        bit          on, pn;
        logic [13:0] ex;
        brightness = br;
        e0 = edge_cnt;
        for (int j = 0; j < 64; j++) begin
            k  = j / 16;
            sl = j % 16;
            on = !blk[k] && (sl <= int'(br));
            pn = (j == 63) ? pe : ((ld_j >= 0 && j >= ld_j) ? 1'b1 : ps);
            ex[13]   = (j == 63);
            ex[12]   = pn;
            ex[11:8] = on ? ~(4'b0001 << k) : 4'hF;
            ex[7:1]  = on ? glyph(codes[5*k +: 5]) : 7'h7F;
            ex[0]    = on ? ~dpv[k] : 1'b1;
            push(e0 + 1 + j, ex, nm);
        end
        for (int j = 0; j < 64; j++) begin
            load = (j == ld_j);
            if (j == ld_j) begin
                digits_in = ld_codes;
                dp_in     = ld_dp;
                blank_in  = ld_blank;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    localparam logic [19:0] C3210 = {5'd3, 5'd2, 5'd1, 5'd0};
    localparam logic [19:0] CABCD = {5'd10, 5'd11, 5'd12, 5'd13};
    localparam logic [19:0] CMIX  = {5'd25, 5'd16, 5'd17, 5'd0};

    initial begin
        reset = 1'b1;
        digits_in = '0; dp_in = '0; blank_in = '0; load = 1'b0; brightness = 4'd15;
        @(negedge clk);
        push(edge_cnt + 1, {1'b0, 1'b0, 4'hF, 7'h7F, 1'b1}, "reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_frame('0,    4'b0000, 4'hF,    4'd15, 1'b0, 10, 1'b0, C3210, 4'b0000, 4'b0000, "f0_reset_blank");
        run_frame(C3210, 4'b0000, 4'h0,    4'd15, 1'b0, 20, 1'b0, CABCD, 4'b0000, 4'b0000, "f1_digits");
        run_frame(CABCD, 4'b0000, 4'h0,    4'd15, 1'b0, 63, 1'b1, CMIX,  4'b0001, 4'b0100, "f2_wrap_load");
        run_frame(CABCD, 4'b0000, 4'h0,    4'd0,  1'b1, -1, 1'b0, '0,    4'b0000, 4'b0000, "f3_bright0");
        run_frame(CMIX,  4'b0001, 4'b0100, 4'd7,  1'b0, 5,  1'b0, CMIX,  4'b0000, 4'b0000, "f4_blank_dp");
        run_frame(CMIX,  4'b0000, 4'h0,    4'd15, 1'b0, -1, 1'b0, '0,    4'b0000, 4'b0000, "f5_glyphs");

        digits_in = C3210; dp_in = '0; blank_in = '0; load = 1'b1;
        push(edge_cnt + 1, {1'b0, 1'b1, 4'b1110, 7'h40, 1'b1}, "pending_before_reset");
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        push(edge_cnt, {1'b0, 1'b0, 4'hF, 7'h7F, 1'b1}, "reset_async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        run_frame('0, 4'b0000, 4'hF, 4'd15, 1'b0, 30, 1'b0, '0, 4'b0000, 4'b0000, "post_reset_discard");
        run_frame('0, 4'b0000, 4'b1110, 4'd15, 1'b0, 30, 1'b0, {5'd0, 5'd0, 5'd1, 5'd0}, 4'b0000, 4'b0000,
                  "lzb_all_zero");
        run_frame({5'd0, 5'd0, 5'd1, 5'd0}, 4'b0000, 4'b1100, 4'd15, 1'b0, -1, 1'b0, '0, 4'b0000, 4'b0000,
                  "lzb_0010");
`else
        run_frame('0, 4'b0000, 4'hF, 4'd15, 1'b0, -1, 1'b0, '0, 4'b0000, 4'b0000, "post_reset_discard");
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d items left, need 0", q.size());
            checks += q.size();
            errors += q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It is the successor of the fixed 4-digit hex scanner.
- Adds the following over the fixed scanner:
  - configurable digit count;
  - per-digit decimal point and blanking;
  - 16-level PWM brightness;
  - double-buffered, tear-free updates latched at frame boundaries;
  - a frame-done pulse.
- Sits between the datapath or top-level glue and the board's seg/dp/an pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned, 1..8.
- SLOT_BITS, 18: width of the per-digit slot counter. Each digit is lit for a slot of 2^SLOT_BITS clocks. Must be >= 4.
- IDX_W, $clog2(NUM_DIGITS) (min 1): digit index width. Derived; do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- digits_in  in  5*NUM_DIGITS  5-bit glyph code per digit; digit k occupies bits [5k+4:5k]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_in  in  NUM_DIGITS  1 = digit dark.
- load  in  1  single-cycle strobe that captures digits_in, dp_in and blank_in into the pending buffer.
- brightness  in  4  0 = dimmest on-time, 15 = full on-time.
- pending  out  1  high while a captured update has not yet been applied.
- frame_done  out  1  1-cycle pulse when the last digit's slot ends.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.
- an  out  NUM_DIGITS  anodes, active low.

Behaviour:
- Reset (asynchronous): slot counter = 0; index = 0; both buffers cleared to code 0, dp 0, blank all-ones. Outputs: pending = 0, frame_done = 0, seg = 7'h7F, dp = 1, an = all-ones.
- Slot counter increments every clk. When it reaches 2^SLOT_BITS-1 it wraps to 0 and the index advances.
- Index wraps from NUM_DIGITS-1 to 0 (not 2^IDX_W-1). On that wrap, frame_done pulses for exactly 1 cycle.
- Buffering:
  - load writes the pending buffer and sets pending.
  - A load in the same cycle as a frame wrap is written to pending but not applied; it is applied at the next wrap.
  - At a wrap with pending = 1, pending is copied to the display buffer and pending clears.
  - Repeated loads before a wrap overwrite the pending buffer; the last one wins.
- Glyph decode:
  - codes 0-15 are hex 0-F;
  - 16 is "=" (7'b0110111);
  - 17 is blank (7'h7F);
  - 18-31 are dash (7'b0111111).
- Brightness: the current digit's anode is driven low only while slot_cnt[SLOT_BITS-1 -: 4] <= brightness. brightness = 15 gives 100% on-time; brightness = 0 gives 1/16.
- When the anode is off, seg = 7'h7F and dp = 1.
- A blanked digit keeps its anode high for the whole slot.
- seg, dp and an are registered, with 1-cycle latency from the counter/index state.
- At most one anode is low at any cycle.
- No glitch: an, seg and dp all change in the same registered cycle.
- Reset asserted mid-frame returns all state to reset values immediately. Any pending update is discarded.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - A contiguous run of code-0 digits starting at index NUM_DIGITS-1 is displayed blank.
  - A digit with dp_in = 1 terminates the run.
  - Digit 0 is never suppressed.
  - The suppression mask is computed from the display buffer at apply time and registered with it.
- Undefined: zeros display normally, and no mask logic is synthesised.

Decomposition:
- Package seven_seg_pkg contains:
  - the glyph code constants (CODE_EQ = 16, CODE_BLANK = 17, CODE_DASH = 18);
  - the SEG_OFF = 7'h7F constant;
  - the typedef for a 5-bit glyph code.
- Sub-module seven_seg_decoder: purely combinational, 5-bit code in, 7-bit segments out. It implements the glyph table above.

Test Plan (SLOT_BITS = 4, NUM_DIGITS = 4 unless stated):
1. Reset, then load digits {3,2,1,0} with brightness 15 → after the first frame wrap, an cycles 1110, 1101, 1011, 0111 with 16 clocks each. seg shows 7'h40, 7'h79, 7'h24, 7'h30. frame_done pulses once per 64 clocks.
2. Double buffering:
   - load {A,B,C,D} mid-frame → pending = 1; the displayed values stay old until the wrap, then switch and pending = 0.
   - load on the exact wrap cycle → applied one frame later.
3. brightness 0 → each anode is low for exactly 1 of 16 slot clocks, with seg = 7'h7F otherwise. brightness 7 → 8 of 16 clocks.
4. blank_in = 4'b0100 with dp_in = 4'b0001 → an[2] never goes low. While digit 0 is active, dp = 0; otherwise dp = 1.
5. Codes 16, 17, 25 → seg = 7'b0110111, 7'h7F, 7'b0111111.
6. With the macro defined, load {0,0,0,0} → only digit 0 lights, showing "0". Load {0,0,1,0} → digits 3 and 2 are dark. Assert reset mid-slot → an = all-ones on the same edge.
